// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, HALT opcode and IF/ID layout.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus: valid/ready request, valid-only response.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_hold_reg.sv
// One-entry buffer parking a fetched word while IF/ID is stalled.
module fetch_hold_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  input  logic        drain,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc4;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the data flops are
  // reset as well so the buffer never presents X contents after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC, single-outstanding imem request FSM, IF/ID register,
// redirect/stall handling and HALT stop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                if_id_valid,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc4,
  output logic                halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;
  if_id_t       if_id_q, if_id_d;

  logic        handshake;
  logic        can_accept;
  logic [31:0] req_pc4;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc4;
  logic        hold_load, hold_drain, hold_flush;
  logic        hold_valid;
  logic [31:0] hold_instr, hold_pc4;

  fetch_hold_reg u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .load_instr (imem.imem_rsp_data),
    .load_pc4   (req_pc4),
    .drain      (hold_drain),
    .flush      (hold_flush),
    .valid      (hold_valid),
    .instr      (hold_instr),
    .pc4        (hold_pc4)
  );

  assign handshake  = imem.imem_req_valid & imem.imem_req_ready;
  assign can_accept = ~if_id_q.valid | ~stall;
  assign req_pc4    = req_pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    deliver       = 1'b0;
    deliver_instr = imem.imem_rsp_data;
    deliver_pc4   = req_pc4;
    hold_load     = 1'b0;
    hold_drain    = 1'b0;
    hold_flush    = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // The word for the old pc is already on its way; mark it for discard.
          if (handshake) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (handshake) begin
          req_pc_d = pc_q;
          kill_d   = 1'b0;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            if (redirect_valid) pc_d = redirect_pc;
            state_d = REQ;
          end else if (can_accept) begin
            deliver = 1'b1;
            pc_d    = req_pc4;
            state_d = is_halt(imem.imem_rsp_data[31:26]) ? HALT : REQ;
          end else begin
            hold_load = 1'b1;
            pc_d      = req_pc4;
            state_d   = HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          hold_flush = 1'b1;
          pc_d       = redirect_pc;
          state_d    = REQ;
        end else if (!stall && hold_valid) begin
          hold_drain    = 1'b1;
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          deliver_pc4   = hold_pc4;
          state_d       = is_halt(hold_instr[31:26]) ? HALT : REQ;
        end
      end

      HALT: begin
        // A redirect here means the HALT was fetched down a wrong path.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Redirect beats both delivery and stall; a stall only holds a live entry.
  always_comb begin
    if_id_d = if_id_q;
    if (redirect_valid) begin
      if_id_d.valid = 1'b0;
    end else if (deliver) begin
      if_id_d = '{valid: 1'b1, instr: deliver_instr, pc4: deliver_pc4};
    end else if (!stall) begin
      if_id_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      if_id_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      if_id_q  <= if_id_d;
    end
  end

  assign imem.imem_req_valid = (state_q == REQ);
  assign imem.imem_addr      = pc_q;
  assign halted              = (state_q == HALT);
  assign if_id_valid         = if_id_q.valid;
  assign if_id_instr         = if_id_q.instr;
  assign if_id_pc4           = if_id_q.pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: pipelined fetch, stall/HOLD, redirect kill, HALT,
// mid-transaction reset and PC wrap (second instance with RESET_PC at the top word).
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic stall = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  fetch_unit_if m_if ();
  logic        if_id_valid, halted;
  logic [31:0] if_id_instr, if_id_pc4;

  fetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (m_if.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .halted         (halted)
  );

  // ---------------- wrap instance ----------------
  fetch_unit_if b_if ();
  logic        b_if_id_valid, b_halted;
  logic [31:0] b_if_id_instr, b_if_id_pc4;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk            (clk),
    .rst            (rst2),
    .imem           (b_if.master),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_id_valid    (b_if_id_valid),
    .if_id_instr    (b_if_id_instr),
    .if_id_pc4      (b_if_id_pc4),
    .halted         (b_halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h0000_0000;
      32'h0000_0008: return 32'h3C01_1234;
      32'h0000_000C: return 32'h8C22_0004;
      32'h0000_0010: return 32'hFC00_0000;
      32'h0000_0040: return 32'h2002_0040;
      32'h0000_0044: return 32'h2003_0044;
      32'h0000_0080: return 32'h2004_0080;
      32'hFFFF_FFFC: return 32'h0800_0000;
      default:       return 32'h2000_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  // Main memory model: always ready, response mem_lat cycles after acceptance.
  int          mem_lat = 1;
  logic        inj_rsp = 1'b0;
  logic [31:0] inj_data = '0;
  logic        mdl_rsp_valid;
  logic [31:0] mdl_rsp_data;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  assign m_if.imem_req_ready = 1'b1;
  assign m_if.imem_rsp_valid = mdl_rsp_valid | inj_rsp;
  assign m_if.imem_rsp_data  = inj_rsp ? inj_data : mdl_rsp_data;

  always @(posedge clk) begin
    if (rst) begin
      mdl_rsp_valid <= 1'b0;
      mdl_rsp_data  <= '0;
      pend          <= 1'b0;
      cnt           <= 0;
      paddr         <= '0;
    end else begin
      mdl_rsp_valid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          mdl_rsp_valid <= 1'b1;
          mdl_rsp_data  <= mem_word(paddr);
          pend          <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (m_if.imem_req_valid && m_if.imem_req_ready) begin
        if (mem_lat == 1) begin
          mdl_rsp_valid <= 1'b1;
          mdl_rsp_data  <= mem_word(m_if.imem_addr);
        end else begin
          pend  <= 1'b1;
          paddr <= m_if.imem_addr;
          cnt   <= mem_lat - 1;
        end
      end
    end
  end

  // Wrap instance memory: zero-wait.
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  assign b_if.imem_req_ready = 1'b1;
  assign b_if.imem_rsp_valid = b_rsp_valid;
  assign b_if.imem_rsp_data  = b_rsp_data;

  always @(posedge clk) begin
    if (rst2) begin
      b_rsp_valid <= 1'b0;
      b_rsp_data  <= '0;
    end else begin
      b_rsp_valid <= b_if.imem_req_valid;
      b_rsp_data  <= mem_word(b_if.imem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'h0, m_if.imem_req_valid}, 32'h0);
    check({tag, "_halted"},    {31'h0, halted}, 32'h0);
    check({tag, "_ifid_valid"}, {31'h0, if_id_valid}, 32'h0);
    check({tag, "_ifid_instr"}, if_id_instr, 32'h0);
    check({tag, "_ifid_pc4"},   if_id_pc4, 32'h0);
  endtask

  initial begin
    int req_seen;

    // Reset state
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    check("idle_no_req", {31'h0, m_if.imem_req_valid}, 32'h0);

    // Zero-wait fetch: 0 then 4
    step();
    check("req0_valid", {31'h0, m_if.imem_req_valid}, 32'h1);
    check("req0_addr", m_if.imem_addr, 32'h0);
    step();
    check("wait0_ifid_empty", {31'h0, if_id_valid}, 32'h0);
    step();
    check("ifid0_valid", {31'h0, if_id_valid}, 32'h1);
    check("ifid0_instr", if_id_instr, 32'h2001_0005);
    check("ifid0_pc4", if_id_pc4, 32'h4);
    check("req1_addr", m_if.imem_addr, 32'h4);
    check("req1_valid", {31'h0, m_if.imem_req_valid}, 32'h1);
    step();
    check("bubble", {31'h0, if_id_valid}, 32'h0);
    step();
    check("ifid1_instr", if_id_instr, 32'h0000_0000);
    check("ifid1_pc4", if_id_pc4, 32'h8);
    check("req2_addr", m_if.imem_addr, 32'h8);

    // Stall with live IF/ID while the word for 8 returns -> HOLD
    stall = 1'b1;
    step();
    step();
    check("hold_no_req_a", {31'h0, m_if.imem_req_valid}, 32'h0);
    check("hold_ifid_kept", if_id_pc4, 32'h8);
    check("hold_ifid_valid", {31'h0, if_id_valid}, 32'h1);
    step();
    check("hold_no_req_b", {31'h0, m_if.imem_req_valid}, 32'h0);
    step();
    stall = 1'b0;
    check("hold_no_req_c", {31'h0, m_if.imem_req_valid}, 32'h0);
    mem_lat = 3;
    step();
    check("drain_instr", if_id_instr, 32'h3C01_1234);
    check("drain_pc4", if_id_pc4, 32'hC);
    check("drain_valid", {31'h0, if_id_valid}, 32'h1);
    check("req3_addr", m_if.imem_addr, 32'hC);
    check("req3_valid", {31'h0, m_if.imem_req_valid}, 32'h1);

    // Redirect to 0x40 while waiting; late response must be dropped
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("kill_wait_empty", {31'h0, if_id_valid}, 32'h0);
    step();
    check("kill_rsp_arrives", {31'h0, m_if.imem_rsp_valid}, 32'h1);
    mem_lat = 1;
    step();
    check("kill_discard", {31'h0, if_id_valid}, 32'h0);
    check("redir_req_valid", {31'h0, m_if.imem_req_valid}, 32'h1);
    check("redir_req_addr", m_if.imem_addr, 32'h40);
    step();
    step();
    check("redir_ifid_instr", if_id_instr, 32'h2002_0040);
    check("redir_ifid_pc4", if_id_pc4, 32'h44);

    // Redirect coinciding with a handshake, then HALT at 0x10
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    check("redir_hs_ifid_clear", {31'h0, if_id_valid}, 32'h0);
    step();
    check("redir_hs_discard", {31'h0, if_id_valid}, 32'h0);
    check("redir_hs_addr", m_if.imem_addr, 32'h10);
    step();
    step();
    check("halt_flag", {31'h0, halted}, 32'h1);
    check("halt_ifid_instr", if_id_instr, 32'hFC00_0000);
    check("halt_ifid_pc4", if_id_pc4, 32'h14);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_if.imem_req_valid) req_seen++;
    end
    check("halt_no_req_20", req_seen, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("unhalt_flag", {31'h0, halted}, 32'h0);
    check("unhalt_req_valid", {31'h0, m_if.imem_req_valid}, 32'h1);
    check("unhalt_addr", m_if.imem_addr, 32'h80);

    // Reset while in WAIT with a late stray response
    mem_lat = 3;
    step();
    rst      = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    step();
    check_reset_outputs("midrst");
    rst     = 1'b0;
    inj_rsp = 1'b1;
    mem_lat = 1;
    step();
    inj_rsp = 1'b0;
    check("midrst_ignored", {31'h0, if_id_valid}, 32'h0);
    check("midrst_req_valid", {31'h0, m_if.imem_req_valid}, 32'h1);
    check("midrst_req_addr", m_if.imem_addr, 32'h0);
    step();
    step();
    check("midrst_ifid_instr", if_id_instr, 32'h2001_0005);
    check("midrst_ifid_pc4", if_id_pc4, 32'h4);

    // PC wrap from 0xFFFF_FFFC
    rst2 = 1'b0;
    step();
    check("wrap_req_addr", b_if.imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    check("wrap_ifid_pc4", b_if_id_pc4, 32'h0);
    check("wrap_ifid_instr", b_if_id_instr, 32'h0800_0000);
    check("wrap_next_addr", b_if.imem_addr, 32'h0);
    check("wrap_next_valid", {31'h0, b_if.imem_req_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
